// File: rtl/flit_packetizer_pkg.sv
// Shared constants for the flit packetizer and its FIFO read-side counterpart:
// one-hot flit types, FSM state encodings and header field offsets.
package flit_packetizer_pkg;

  // One-hot flit type codes, identical to those decoded by the FIFO reader.
  localparam logic [2:0] FLIT_NONE    = 3'b000;
  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  // Packetizer FSM state encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // Header layout, low to high: destination, source, length, zero fill.
  localparam int HDR_DST_LSB = 0;

  function automatic int hdr_src_lsb(input int addr_width);
    return HDR_DST_LSB + addr_width;
  endfunction

  function automatic int hdr_len_lsb(input int addr_width);
    return HDR_DST_LSB + 2 * addr_width;
  endfunction

endpackage

// File: rtl/flit_packetizer.sv
// flit_packetizer: turns a packet request plus a stream of data words into a
// header / payload / tail flit sequence written into a router input FIFO.
// Optional feature macro: FLIT_PACKETIZER_PKT_CNT_EN adds a 16-bit counter of
// completed packets on pkt_count; without it pkt_count is tied to zero.
module flit_packetizer
  import flit_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] SRC_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_req,
  input  logic [ADDR_WIDTH-1:0] pkt_dst,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  pkt_ack,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic [2:0]            flit_type,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int SRC_LSB = hdr_src_lsb(ADDR_WIDTH);
  localparam int LEN_LSB = hdr_len_lsb(ADDR_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [1:0]            state_reg, state_next;
  logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
  logic [ADDR_WIDTH-1:0] dst_reg, dst_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;

  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [DATA_WIDTH-1:0] header_word;
  logic                  last_word;
  logic                  tail_write;

  // A zero-length request still carries one word so every packet has a tail.
  assign len_clamped = (pkt_len == '0) ? LEN_ONE : pkt_len;

  // The remaining-word counter reaching one marks the tail flit.
  assign last_word  = (rem_reg == LEN_ONE);
  assign tail_write = (state_reg == ST_PAYLOAD) && last_word && wr_en;

  assign busy = (state_reg != ST_IDLE);

  // Header flit assembled from the latched request fields.
  always_comb begin
    header_word = '0;
    header_word[HDR_DST_LSB +: ADDR_WIDTH] = dst_reg;
    header_word[SRC_LSB +: ADDR_WIDTH]     = SRC_ADDR;
    header_word[LEN_LSB +: LEN_WIDTH]      = len_reg;
  end

  // Handshake and FIFO-side outputs decoded from the current state.
  always_comb begin
    pkt_ack   = 1'b0;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    flit_type = FLIT_NONE;
    flit_data = '0;
    case (state_reg)
      ST_IDLE: begin
        pkt_ack = pkt_req;
      end
      ST_HEADER: begin
        flit_type = FLIT_HEADER;
        flit_data = header_word;
        wr_en     = !full;
      end
      ST_PAYLOAD: begin
        // Data words pass straight through; the FIFO registers them.
        flit_type = last_word ? FLIT_TAIL : FLIT_PAYLOAD;
        flit_data = in_data;
        in_ready  = !full;
        wr_en     = in_valid && !full;
      end
      default: begin
        flit_type = FLIT_NONE;
      end
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pkt_req) begin
          dst_next   = pkt_dst;
          len_next   = len_clamped;
          rem_next   = len_clamped;
          state_next = ST_HEADER;
        end
      end
      ST_HEADER: begin
        // While full the header is simply re-presented next cycle.
        if (!full) begin
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // Bubbles and full cycles leave the counter untouched.
        if (wr_en) begin
          rem_next = rem_reg - LEN_ONE;
        end
        if (tail_write) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
    end
  end

`ifdef FLIT_PACKETIZER_PKT_CNT_EN
  logic [15:0] pkt_count_reg;

  // Count completed packets on each tail write; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_reg <= 16'd0;
    end else if (tail_write) begin
      pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

  assign pkt_count = pkt_count_reg;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// Self-checking bench for flit_packetizer. A queue-based model predicts the
// flit sequence of each accepted packet; a negedge monitor compares every
// cycle, and directed tests pin timing and literal values.
module tb_flit_packetizer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 8;
  localparam logic [AW-1:0] SRC = 4'd0;

  logic          clk = 1'b0;
  logic          rst;
  logic          pkt_req;
  logic [AW-1:0] pkt_dst;
  logic [LW-1:0] pkt_len;
  logic          pkt_ack;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          full;
  logic          wr_en;
  logic [DW-1:0] flit_data;
  logic [2:0]    flit_type;
  logic          busy;
  logic [15:0]   pkt_count;

  flit_packetizer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SRC_ADDR(SRC)
  ) dut (
    .clk(clk), .rst(rst), .pkt_req(pkt_req), .pkt_dst(pkt_dst),
    .pkt_len(pkt_len), .pkt_ack(pkt_ack), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .full(full), .wr_en(wr_en),
    .flit_data(flit_data), .flit_type(flit_type), .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic [2:0] ftype; } flit_t;
  typedef struct { int cyc; logic [2:0] ftype; logic [DW-1:0] data; } wrec_t;

  flit_t         exp_q[$];
  logic [DW-1:0] src_q[$];
  bit            vpat[$];
  bit            fpat[$];
  wrec_t         wlog[$];

  int          cyc = 0;
  int          ack_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          send_seq = 0;
  int          model_seq = 0;
  logic [15:0] model_cnt = 16'd0;

`ifdef FLIT_PACKETIZER_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  function automatic logic [DW-1:0] word_of(input int k, input int i);
    return {8'hC0, 8'(k), 16'(i)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the model once per cycle.
  bit            m_idle, m_hdr, m_exp_wr;
  int            m_len;
  logic [DW-1:0] m_hdr_word;
  logic [15:0]   m_exp_cnt;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        src_q.delete();
        vpat.delete();
        fpat.delete();
        model_cnt = 16'd0;
      end else begin
        m_idle    = (exp_q.size() == 0);
        m_exp_cnt = CNT_EN ? model_cnt : 16'd0;
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("pkt_ack", 32'(pkt_ack), 32'(m_idle && pkt_req));
        chk("pkt_count", 32'(pkt_count), 32'(m_exp_cnt));
        if (m_idle) begin
          chk("idle_wr_en", 32'(wr_en), 32'd0);
          chk("idle_in_ready", 32'(in_ready), 32'd0);
          chk("idle_flit_type", 32'(flit_type), 32'd0);
          chk("idle_flit_data", flit_data, 32'd0);
        end else begin
          m_hdr    = (exp_q[0].ftype == 3'b001);
          m_exp_wr = !full && (m_hdr || in_valid);
          chk("wr_en", 32'(wr_en), 32'(m_exp_wr));
          chk("in_ready", 32'(in_ready), 32'(!m_hdr && !full));
          chk("flit_type", 32'(flit_type), 32'(exp_q[0].ftype));
          if (m_hdr || wr_en) chk("flit_data", flit_data, exp_q[0].data);
          if (wr_en) begin
            wlog.push_back('{cyc, flit_type, flit_data});
            if (exp_q[0].ftype == 3'b100) model_cnt = model_cnt + 16'd1;
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready && src_q.size() > 0) void'(src_q.pop_front());
        if (pkt_ack && m_idle) begin
          ack_cyc    = cyc;
          m_len      = (pkt_len == 0) ? 1 : int'(pkt_len);
          m_hdr_word = 32'(pkt_dst) | (32'(SRC) << AW) | (32'(m_len) << (2 * AW));
          exp_q.push_back('{m_hdr_word, 3'b001});
          for (int i = 0; i < m_len; i++)
            exp_q.push_back('{word_of(model_seq, i), (i == m_len - 1) ? 3'b100 : 3'b010});
          model_seq++;
        end
      end
    end
  end

  // Data/full driver: applies per-cycle patterns, defaults to valid data, not full.
  bit d_v, d_f;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      d_f = 1'b0;
      d_v = 1'b1;
      if (fpat.size() > 0) d_f = fpat.pop_front();
      if (vpat.size() > 0) d_v = vpat.pop_front();
      full     = d_f;
      in_valid = d_v && (src_q.size() > 0);
      in_data  = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
    end
  end

  task automatic send(input logic [AW-1:0] d, input logic [LW-1:0] l);
    int n;
    bit got;
    n   = (l == 0) ? 1 : int'(l);
    got = 1'b0;
    for (int i = 0; i < n; i++) src_q.push_back(word_of(send_seq, i));
    send_seq++;
    pkt_dst = d;
    pkt_len = l;
    pkt_req = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (pkt_ack) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no pkt_ack expected pkt_ack within 200 cycles");
    end
    next_cycle();
    pkt_req = 1'b0;
    pkt_dst = ~d;
    pkt_len = ~l;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      next_cycle();
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending flits expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pkt_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int k;
  int tail_a;
  initial begin
    rst = 1'b1; pkt_req = 1'b0; pkt_dst = '0; pkt_len = '0;
    in_data = '0; in_valid = 1'b0; full = 1'b0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pkt_ack", 32'(pkt_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flit_type", 32'(flit_type), 32'd0);
    chk("rst_flit_data", flit_data, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    next_cycle();

    // 1: dst=3 len=3, streaming.
    wlog.delete();
    send(4'd3, 8'd3);
    wait_idle();
    $display("test1: %0d writes, ack at cycle %0d", wlog.size(), ack_cyc);
    chk("t1_writes", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("t1_hdr_data", wlog[0].data, 32'h0000_0303);
      chk("t1_hdr_cyc", 32'(wlog[0].cyc), 32'(ack_cyc + 1));
      chk("t1_type1", 32'(wlog[1].ftype), 32'h2);
      chk("t1_type2", 32'(wlog[2].ftype), 32'h2);
      chk("t1_tail_type", 32'(wlog[3].ftype), 32'h4);
      chk("t1_tail_cyc", 32'(wlog[3].cyc), 32'(ack_cyc + 4));
    end

    // 2: len=1 then len=0 (clamped to 1).
    wlog.delete();
    send(4'd6, 8'd1);
    wait_idle();
    send(4'd5, 8'd0);
    wait_idle();
    $display("test2: %0d writes", wlog.size());
    chk("t2_writes", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("t2_len1_hdr", wlog[0].data, 32'h0000_0106);
      chk("t2_len1_tail", 32'(wlog[1].ftype), 32'h4);
      chk("t2_len0_hdr", wlog[2].data, 32'h0000_0105);
      chk("t2_len0_tail", 32'(wlog[3].ftype), 32'h4);
    end

    // 3: full on the header for 3 cycles and mid-payload, with valid toggling.
    wlog.delete();
    fpat = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    vpat = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1};
    send(4'd9, 8'd3);
    wait_idle();
    $display("test3: %0d writes, ack at cycle %0d", wlog.size(), ack_cyc);
    chk("t3_writes", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("t3_hdr_cyc", 32'(wlog[0].cyc), 32'(ack_cyc + 4));
      chk("t3_tail_cyc", 32'(wlog[3].cyc), 32'(ack_cyc + 10));
    end

    // 4: input bubbles 1,0,0,1,1 during the payload.
    wlog.delete();
    k = send_seq;
    send(4'd2, 8'd3);
    next_cycle();
    vpat = '{1, 0, 0, 1, 1};
    wait_idle();
    $display("test4: %0d writes, ack at cycle %0d", wlog.size(), ack_cyc);
    chk("t4_writes", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("t4_p2_cyc", 32'(wlog[2].cyc), 32'(ack_cyc + 5));
      chk("t4_tail_cyc", 32'(wlog[3].cyc), 32'(ack_cyc + 6));
      chk("t4_tail_data", wlog[3].data, word_of(k, 2));
    end

    // 5: second request raised while the first packet is in its payload.
    wlog.delete();
    send(4'd1, 8'd4);
    next_cycle();
    send(4'd2, 8'd2);
    wait_idle();
    tail_a = -1;
    foreach (wlog[i]) if (tail_a < 0 && wlog[i].ftype == 3'b100) tail_a = wlog[i].cyc;
    $display("test5: %0d writes, second ack at cycle %0d", wlog.size(), ack_cyc);
    chk("t5_writes", 32'(wlog.size()), 32'd8);
    chk("t5_ack_after_gap", 32'(ack_cyc), 32'(tail_a + 1));

    // Maximum length must complete without wrapping.
    wlog.delete();
    send(4'hF, 8'hFF);
    wait_idle();
    $display("maxlen: %0d writes", wlog.size());
    chk("max_writes", 32'(wlog.size()), 32'd256);
    if (wlog.size() == 256) begin
      chk("max_hdr", wlog[0].data, 32'h0000_FF0F);
      chk("max_tail_type", 32'(wlog[255].ftype), 32'h4);
    end

    // 6: reset after the second payload flit.
    vpat = '{1, 1, 1, 1, 0};
    send(4'd7, 8'd3);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    $display("test6: after mid-packet reset busy=%0d wr_en=%0d", busy, wr_en);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    next_cycle();
    send(4'd1, 8'd2);
    wait_idle();
    send(4'd2, 8'd0);
    wait_idle();
    @(negedge clk);
    $display("test6: pkt_count=%0d", pkt_count);
    chk("t6_count2", 32'(pkt_count), CNT_EN ? 32'd2 : 32'd0);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk("t6_count_rst", 32'(pkt_count), 32'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
